// File: rtl/bka_pkg.sv
// Shared types and sizing helpers for the Brent-Kung prefix adder family.
package bka_pkg;

    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Up-sweep plus down-sweep depth of a Brent-Kung tree covering width bits.
    function automatic int bka_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

endpackage

// File: rtl/bka_black_cell.sv
// Brent-Kung black cell: merges a high group with the adjacent low group.
module bka_black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/pipelined_bka_adder.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// The prefix tree is padded to a power of two; register cuts are spread over its levels.
module pipelined_bka_adder
    import bka_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LOG_N  = $clog2(WIDTH);
    localparam int N      = 1 << LOG_N;
    localparam int LEVELS = bka_levels(WIDTH);
    localparam int CUTS   = PIPE_STAGES - 1;

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_in_s;
    logic [N-1:0]     a_pad_s;
    logic [N-1:0]     b_pad_s;
    logic [N-1:0]     g0_s;
    logic [N-1:0]     p0_s;
    pg_t              bit_pg_s [N];

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = advance_s;

    // Stage 0: mode select, padding and bitwise g/p; carry-in is folded into bit 0's generate
    always_comb begin
        b_eff_s = sub ? ~b : b;
        c0_in_s = sub ? 1'b1 : cin;
        a_pad_s = N'(a);
        b_pad_s = N'(b_eff_s);
        g0_s    = '0;
        p0_s    = '0;
        for (int i = 0; i < N; i++) begin
            bit_pg_s[i].g = a_pad_s[i] & b_pad_s[i];
            bit_pg_s[i].p = a_pad_s[i] ^ b_pad_s[i];
            g0_s[i]       = bit_pg_s[i].g;
            p0_s[i]       = bit_pg_s[i].p;
        end
        g0_s[0] = bit_pg_s[0].g | (bit_pg_s[0].p & c0_in_s);
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        logic [N-1:0]     g_s;
        logic [N-1:0]     p_s;
        logic [WIDTH-1:0] hs_s;
        logic             c0_s;
        logic             v_s;

        if (k == 0) begin : g_src
            assign g_s  = g0_s;
            assign p_s  = p0_s;
            assign hs_s = p0_s[WIDTH-1:0];
            assign c0_s = c0_in_s;
            assign v_s  = in_valid;
        end else begin : g_tree
            localparam bit UP  = (k <= LOG_N);
            localparam int D   = UP ? (1 << (k - 1)) : (1 << (2 * LOG_N - 1 - k));
            localparam bit CUT = ((k * CUTS) / LEVELS) > (((k - 1) * CUTS) / LEVELS);

            logic [N-1:0] gc_s;
            logic [N-1:0] pc_s;

            for (genvar i = 0; i < N; i++) begin : g_node
                localparam bit JOIN = UP ? (((i + 1) % (2 * D)) == 0)
                                         : ((((i + 1) % (2 * D)) == D) && ((i + 1) >= 3 * D));
                if (JOIN) begin : g_cell
                    bka_black_cell u_cell (
                        .g_hi  (g_lvl[k-1].g_s[i]),
                        .p_hi  (g_lvl[k-1].p_s[i]),
                        .g_lo  (g_lvl[k-1].g_s[i-D]),
                        .p_lo  (g_lvl[k-1].p_s[i-D]),
                        .g_out (gc_s[i]),
                        .p_out (pc_s[i])
                    );
                end else begin : g_pass
                    assign gc_s[i] = g_lvl[k-1].g_s[i];
                    assign pc_s[i] = g_lvl[k-1].p_s[i];
                end
            end

            if (CUT) begin : g_cut
                logic [N-1:0]     g_r;
                logic [N-1:0]     p_r;
                logic [WIDTH-1:0] hs_r;
                logic             c0_r;
                logic             v_r;

                // Inter-level pipeline register; every stage holds together while the output stalls
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        g_r  <= '0;
                        p_r  <= '0;
                        hs_r <= '0;
                        c0_r <= 1'b0;
                        v_r  <= 1'b0;
                    end else if (advance_s) begin
                        g_r  <= gc_s;
                        p_r  <= pc_s;
                        hs_r <= g_lvl[k-1].hs_s;
                        c0_r <= g_lvl[k-1].c0_s;
                        v_r  <= g_lvl[k-1].v_s;
                    end
                end

                assign g_s  = g_r;
                assign p_s  = p_r;
                assign hs_s = hs_r;
                assign c0_s = c0_r;
                assign v_s  = v_r;
            end else begin : g_wire
                assign g_s  = gc_s;
                assign p_s  = pc_s;
                assign hs_s = g_lvl[k-1].hs_s;
                assign c0_s = g_lvl[k-1].c0_s;
                assign v_s  = g_lvl[k-1].v_s;
            end
        end
    end

    logic [WIDTH-1:0] carry_in_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic             unused_s;

    // Prefix generates are carries out of each bit; shift them up one place to get carries in
    always_comb begin
        carry_in_s = {g_lvl[LEVELS].g_s[WIDTH-2:0], g_lvl[LEVELS].c0_s};
        sum_s      = g_lvl[LEVELS].hs_s ^ carry_in_s;
        cout_s     = g_lvl[LEVELS].g_s[WIDTH-1];
        ovf_s      = carry_in_s[WIDTH-1] ^ cout_s;
    end

    assign unused_s = ^{g_lvl[LEVELS].p_s, g_lvl[LEVELS].g_s};

    // Output register: the final pipeline cut, frozen while downstream is not ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= g_lvl[LEVELS].v_s;
            sum_r       <= sum_s;
            cout_r      <= cout_s;
            ovf_r       <= ovf_s;
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_bka_adder.sv
// Scoreboard bench: several width/depth configurations run concurrently against a behavioural model.
module tb_pipelined_bka_adder;

    localparam int NCFG = 8;
    localparam int CFG_W [NCFG] = '{32, 31, 8, 8, 31, 31, 32, 32};
    localparam int CFG_P [NCFG] = '{2, 3, 1, 6, 1, 10, 1, 10};
    localparam int NRAND = 1250;

    localparam int NDIR = 8;
    localparam int          DW [NDIR] = '{32, 32, 32, 32, 31, 31, 8, 8};
    localparam logic [63:0] DA [NDIR] = '{64'h7FFF_FFFF, 64'hFFFF_FFFF, 64'h5, 64'h8000_0000,
                                          64'h2AAA_AAAA, 64'h2AAA_AAAA, 64'h7F, 64'h0};
    localparam logic [63:0] DB [NDIR] = '{64'h1, 64'hFFFF_FFFF, 64'h7, 64'h1,
                                          64'h5555_5555, 64'h5555_5555, 64'h1, 64'h0};
    localparam logic        DC [NDIR] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        DS [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    // Expected values packed as {ovf, cout, sum}
    localparam logic [65:0] DE [NDIR] = '{{1'b1, 1'b0, 64'h8000_0000}, {1'b0, 1'b1, 64'hFFFF_FFFF},
                                          {1'b0, 1'b0, 64'hFFFF_FFFE}, {1'b1, 1'b1, 64'h7FFF_FFFF},
                                          {1'b0, 1'b1, 64'h0},         {1'b0, 1'b0, 64'h7FFF_FFFF},
                                          {1'b1, 1'b0, 64'h80},        {1'b0, 1'b1, 64'h0}};

    logic clk;
    int   n_pass;
    int   n_total;
    int   n_done;

    initial begin
        clk     = 1'b0;
        n_pass  = 0;
        n_total = 0;
        n_done  = 0;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar ci = 0; ci < NCFG; ci++) begin : g_cfg
        localparam int W = CFG_W[ci];
        localparam int P = CFG_P[ci];

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [65:0]  obs_s;
        logic [65:0]  sb [$];
        logic         held_v;
        logic [65:0]  held_d;
        logic         rnd_done;

        pipelined_bka_adder #(
            .WIDTH       (W),
            .PIPE_STAGES (P)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        assign obs_s = {ovf, cout, 64'(sum)};

        task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
            check($sformatf("w%0d_p%0d_%s", W, P, tag), obs, exp);
        endtask

        function automatic logic [65:0] model(input logic [63:0] va, input logic [63:0] vb,
                                              input logic vc, input logic vs);
            logic [63:0] mask;
            logic [63:0] am;
            logic [63:0] bm;
            logic [63:0] sm;
            logic [64:0] s;
            logic        co;
            logic        ov;
            mask = (W == 64) ? '1 : ((64'd1 << W) - 64'd1);
            am   = va & mask;
            bm   = (vs ? ~vb : vb) & mask;
            s    = {1'b0, am} + {1'b0, bm} + {64'd0, (vs ? 1'b1 : vc)};
            sm   = s[63:0] & mask;
            co   = s[W];
            ov   = (am[W-1] == bm[W-1]) && (sm[W-1] != am[W-1]);
            return {ov, co, sm};
        endfunction

        // Offer one operation, wait for acceptance and push its expected result
        task automatic send(input logic [63:0] va, input logic [63:0] vb, input logic vc,
                            input logic vs, input logic [65:0] ve);
            int t;
            a        = va[W-1:0];
            b        = vb[W-1:0];
            cin      = vc;
            sub      = vs;
            in_valid = 1'b1;
            t        = 0;
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (in_ready) sb.push_back(ve);
            else chk("accept_timeout", 66'(in_ready), 66'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic send_rand();
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rc;
            logic        rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = 64'd0;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        endtask

        task automatic lat_probe(input logic [63:0] va, input logic [63:0] vb, input logic vc,
                                 input logic vs, input logic [65:0] ve);
            int cyc;
            send(va, vb, vc, vs, ve);
            cyc = 1;
            while (!out_valid && cyc < 64) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("latency", 66'(cyc), 66'(P));
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            int t;
            out_ready = 1'b1;
            t = 0;
            while (sb.size() != 0 && t < P + 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("drain_empty", 66'(sb.size()), 66'd0);
        endtask

        // Output monitor: in-order scoreboard compare plus stability while stalled
        always @(negedge clk) begin
            if (!rst_n) begin
                sb.delete();
                held_v <= 1'b0;
            end else begin
                if (held_v) begin
                    chk("stall_valid", 66'(out_valid), 66'd1);
                    chk("stall_stable", obs_s, held_d);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("spurious_out_valid", 66'(out_valid), 66'd0);
                    else chk("result", obs_s, sb.pop_front());
                end
                held_v <= out_valid && !out_ready;
                held_d <= obs_s;
            end
        end

        initial begin
            rst_n     = 1'b1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            a         = '0;
            b         = '0;
            cin       = 1'b0;
            sub       = 1'b0;
            rnd_done  = 1'b0;
            #1;
            rst_n = 1'b0;
            #2;
            chk("reset_state", {63'd0, out_valid, cout, ovf, 64'(sum)}, 66'd0);
            @(negedge clk);
            #3;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("idle_in_ready", 66'(in_ready), 66'd1);

            for (int k = 0; k < NDIR; k++) begin
                if (DW[k] == W) lat_probe(DA[k], DB[k], DC[k], DS[k], DE[k]);
            end

            // Backpressure: four back-to-back ops, output held off for three cycles
            fork
                begin
                    for (int k = 0; k < 4; k++) send_rand();
                end
                begin
                    int t;
                    t = 0;
                    while (!out_valid && t < 64) begin
                        @(posedge clk);
                        #1;
                        t++;
                    end
                    chk("bp_out_valid_seen", 66'(out_valid), 66'd1);
                    out_ready = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("bp_in_ready_low", 66'(in_ready), 66'd0);
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1'b1;
                end
            join
            drain();

            // Asynchronous reset with operations in flight
            send_rand();
            send_rand();
            #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_out_valid", 66'(out_valid), 66'd0);
            chk("midrst_outputs", {ovf, cout, 64'(sum)}, 66'd0);
            @(negedge clk);
            #2;
            rst_n = 1'b1;
            repeat (P + 4) begin
                @(posedge clk);
                #1;
            end
            chk("post_rst_quiet", 66'(out_valid), 66'd0);
            lat_probe(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
                      model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0));

            // Random traffic with random gaps and random downstream stalls
            fork
                begin
                    for (int k = 0; k < NRAND; k++) begin
                        repeat ($urandom_range(0, 1)) begin
                            @(posedge clk);
                            #1;
                        end
                        send_rand();
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk);
                        #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1'b1;
                end
            join
            drain();
            n_done++;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (n_done < NCFG && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        check("all_configs_done", 66'(n_done), 66'(NCFG));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_bka_adder.md
Name: pipelined_bka_adder

Overview:
Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready handshakes on input and output. It is the next generation of the fixed-width combinational BKA adder: width and pipeline depth are configurable, and it adds a subtract mode, a signed-overflow flag and backpressure. It sits between operand sources and downstream arithmetic stages and sustains one operation per clock when not stalled.

Parameters:
WIDTH, 32, operand/sum width in bits (2..64)
PIPE_STAGES, 2, number of register stages (1..2*clog2(WIDTH)); equals latency in cycles

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (in sub mode: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- One clock, clk; rst_n is asynchronous and active-low. Assertion immediately clears all stage valid bits and data registers: out_valid=0, sum=0, cout=0, ovf=0. in_ready is 1 while rst_n is high and the pipe is empty.
- Datapath: stage 0 forms b_eff = sub ? ~b : b and c0 = sub ? 1 : cin, then bitwise g/p; Brent-Kung up-sweep and down-sweep prefix tree; sum = p ^ carries; cout = final group generate; ovf = carry into MSB ^ carry out of MSB.
- Register cuts: PIPE_STAGES register boundaries, the last always at the outputs; remaining cuts spread evenly across prefix levels (placement is an implementation choice, latency is not). Each stage carries a valid bit plus its partial g/p and b_eff/c0 state.
- Handshake: advance = !out_valid || out_ready; in_ready = advance. On advance, every stage shifts one step, and stage 0 loads operands when in_valid && in_ready. With !advance, all stages hold and outputs stay stable (sum/cout/ovf must not change while out_valid && !out_ready).
- Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output). Results emerge in order, exactly PIPE_STAGES cycles after acceptance when unstalled. Bubbles propagate as valid=0 and are not collapsed.
- Throughput: 1 op/cycle with out_ready held high.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- Reset mid-operation: all in-flight ops are discarded and no spurious out_valid appears after deassertion.
- Width rules: all arithmetic is modulo 2^WIDTH; cout and ovf are computed at exactly WIDTH bits. WIDTH not a power of two: the tree is padded internally to 2^clog2(WIDTH) with p=0, g=0 upper bits, and cout is taken at bit WIDTH-1.

Decomposition:
- Package bka_pkg: pg_t struct {g, p}; function bka_levels(width) = 2*clog2(width)-1; constant MAX_WIDTH = 64.
- Sub-module bka_black_cell: (g_hi,p_hi,g_lo,p_lo) -> (g_hi | p_hi&g_lo, p_hi&p_lo), instantiated by generate loops per prefix level.
- Pipeline registers, handshake and stage-0 mode logic live in the top module.

Test Plan:
1. WIDTH=32: a=0x7FFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> after PIPE_STAGES cycles sum=0x8000_0000, cout=0, ovf=1.
2. a=0xFFFF_FFFF, b=0xFFFF_FFFF, cin=1, sub=0 -> sum=0xFFFF_FFFF, cout=1, ovf=0. Then sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
3. WIDTH=31, PIPE_STAGES=3: a=0x2AAA_AAAA, b=0x5555_5555, cin=1 -> sum=0, cout=1, ovf=0. Same with cin=0 -> sum=0x7FFF_FFFF, cout=0, ovf=0.
4. Backpressure: stream 4 ops back-to-back, hold out_ready low 3 cycles once out_valid rises -> out_valid held, sum stable, in_ready=0 throughout. On release, all 4 results arrive in order with none lost or duplicated.
5. Reset mid-stream: assert rst_n low with 2 ops in flight, asynchronously to clk -> out_valid=0 and sum=0 immediately. After release, no stale result emerges and the first new op completes with latency PIPE_STAGES.
6. Random sweep over PIPE_STAGES in {1, max}, WIDTH in {8, 31, 32}, 10k ops with random in_valid/out_ready -> every result matches reference model {cout,sum} = a + (sub ? ~b+1 : b+cin) and its ovf; order preserved.
